// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store stage driving a req/ack word bus, stalling the datapath until the access completes
module data_mem_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        misaligned,
    output logic        busError,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busByteEn,
    input  logic [31:0] busRdata,
    input  logic        busAck
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0] f3;
    logic [1:0] lane;
    logic req, illegal, mis, start, timeout;
    logic [3:0] byte_en;
    logic [31:0] wdata, load_val;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    always_comb begin
        req = memRead | memWrite;
        illegal = (memRead & memWrite) | (memRead & (funct3 == 3'b011 | funct3[2:1] == 2'b11))
                | (memWrite & (funct3[2] | funct3[1:0] == 2'b11));
        mis = funct3[1:0] == 2'b01 ? address[0] : funct3[1:0] == 2'b10 ? |address[1:0] : 1'b0;
        start = state == IDLE & req & ~illegal & ~mis;
        byte_en = funct3[1:0] == 2'b10 ? 4'b1111 :
                  funct3[1:0] == 2'b01 ? (address[1] ? 4'b1100 : 4'b0011) : 4'b0001 << address[1:0];
        wdata = funct3[1:0] == 2'b10 ? writeData :
                funct3[1:0] == 2'b01 ? {2{writeData[15:0]}} : {4{writeData[7:0]}};
        timeout = TIMEOUT_CYCLES != 0 && !busAck && cnt == CW'(TIMEOUT_CYCLES - 1);
        // lane and size come from the request captured in IDLE, not the live inputs
        rbyte = busRdata[{lane, 3'b000} +: 8];
        rhalf = busRdata[{lane[1], 4'b0000} +: 16];
        load_val = f3[1:0] == 2'b10 ? busRdata :
                   f3[1:0] == 2'b01 ? {{16{~f3[2] & rhalf[15]}}, rhalf} : {{24{~f3[2] & rbyte[7]}}, rbyte};
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state == IDLE ? (req ? (illegal | mis ? DONE : WAIT) : IDLE) :
                     state == WAIT ? (busAck | timeout ? DONE : WAIT) : IDLE;
    end
    always_comb begin
        stall = (state == IDLE & req) | state == WAIT;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData <= '0;
            misaligned <= 1'b0;
            busError <= 1'b0;
            busReq <= 1'b0;
            busWe <= 1'b0;
            busAddr <= '0;
            busWdata <= '0;
            busByteEn <= '0;
            cnt <= '0;
            f3 <= '0;
            lane <= '0;
        end else begin
            misaligned <= state == IDLE && req && !illegal && mis;
            busError <= (state == IDLE && req && illegal) || (state == WAIT && timeout);
            if (start) begin
                busReq <= 1'b1;
                busWe <= memWrite;
                busAddr <= {address[31:2], 2'b00};
                busWdata <= wdata;
                busByteEn <= byte_en;
                cnt <= '0;
                f3 <= funct3;
                lane <= address[1:0];
            end else if (state == WAIT) begin
                if (busAck) begin
                    busReq <= 1'b0;
                    if (!busWe) readData <= load_val;
                end else if (timeout) begin
                    busReq <= 1'b0;
                    readData <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: table vectors, hand-written corner sequences and a randomized run against a behavioural model
module tb_data_mem_unit;
    logic clk = 1'b0, reset = 1'b1;
    logic memRead = 1'b0, memWrite = 1'b0, busAck = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] address = '0, writeData = '0, busRdata = '0;
    logic [31:0] readData, busAddr, busWdata;
    logic stall, misaligned, busError, busReq, busWe;
    logic [3:0] busByteEn;
    logic [31:0] readData_z, busAddr_z, busWdata_z;
    logic stall_z, misaligned_z, busError_z, busReq_z, busWe_z;
    logic [3:0] busByteEn_z;
    int tests = 0, fails = 0;
    bit [31:0] rd_model;

    typedef struct {
        bit rd, wr;
        bit [2:0] f3;
        bit [31:0] addr, wd, rdata;
        int waits;
        bit [31:0] e_rd;
        bit [3:0] e_be;
        bit [31:0] e_wd;
        int e_stall, e_req, e_mis, e_err;
    } vec_t;
    vec_t tbl[$];

    data_mem_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
        .address(address), .writeData(writeData), .readData(readData), .stall(stall),
        .misaligned(misaligned), .busError(busError), .busReq(busReq), .busWe(busWe),
        .busAddr(busAddr), .busWdata(busWdata), .busByteEn(busByteEn), .busRdata(busRdata), .busAck(busAck)
    );
    data_mem_unit #(.TIMEOUT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
        .address(address), .writeData(writeData), .readData(readData_z), .stall(stall_z),
        .misaligned(misaligned_z), .busError(busError_z), .busReq(busReq_z), .busWe(busWe_z),
        .busAddr(busAddr_z), .busWdata(busWdata_z), .busByteEn(busByteEn_z), .busRdata(busRdata), .busAck(busAck)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void add(bit rd, bit wr, bit [2:0] f3, bit [31:0] addr, bit [31:0] wd, bit [31:0] rdata,
                                int waits, bit [31:0] e_rd, bit [3:0] e_be, bit [31:0] e_wd,
                                int e_stall, int e_req, int e_mis, int e_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata; v.waits = waits;
        v.e_rd = e_rd; v.e_be = e_be; v.e_wd = e_wd;
        v.e_stall = e_stall; v.e_req = e_req; v.e_mis = e_mis; v.e_err = e_err;
        tbl.push_back(v);
    endfunction

    // Drives one request from a negedge and plays a bus that acks after `waits` WAIT cycles.
    task automatic run(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, input bit [31:0] rdata, input int waits,
                       output bit [31:0] o_rd, output bit [31:0] o_addr, output bit [31:0] o_wd,
                       output bit [3:0] o_be, output bit o_we,
                       output int o_stall, output int o_req, output int o_mis, output int o_err);
        int w;
        bit done;
        o_rd = '0; o_addr = '0; o_wd = '0; o_be = '0; o_we = 1'b0;
        o_stall = 0; o_req = 0; o_mis = 0; o_err = 0; w = 0; done = 1'b0;
        memRead = rd; memWrite = wr; funct3 = f3; address = addr; writeData = wd; busRdata = rdata; busAck = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (misaligned) o_mis++;
            if (busError) o_err++;
            if (busReq) begin
                o_req++;
                o_be = busByteEn; o_wd = busWdata; o_we = busWe; o_addr = busAddr;
                busAck = (w == waits);
                w++;
            end else busAck = 1'b0;
            if (stall) o_stall++;
            else begin
                done = 1'b1;
                o_rd = readData;
                memRead = 1'b0; memWrite = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        if (misaligned) o_mis++;
        if (busError) o_err++;
        if (!done) begin
            tests++; fails++;
            $display("FAIL budget: access never left stall, got stall=%b expected 0", stall);
        end
    endtask

    task automatic model(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] rdata, input int waits,
                         output int e_req, output int e_stall, output int e_mis, output int e_err,
                         output bit [3:0] e_be, output bit [31:0] e_wd);
        int size, off;
        bit ill;
        bit [31:0] v, mask;
        size = 1 << f3[1:0];
        off = int'(addr % 4);
        ill = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2);
        e_mis = (!ill && off % size != 0) ? 1 : 0;
        e_err = ill ? 1 : 0;
        e_be = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
        if (ill || e_mis == 1) begin
            e_req = 0; e_stall = 1;
        end else begin
            e_req = waits > 3 ? 4 : waits + 1;
            e_stall = e_req + 1;
            if (waits > 3) begin
                e_err = 1; rd_model = '0;
            end else if (rd) begin
                mask = size == 4 ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
                v = (rdata >> (8 * off)) & mask;
                if (!f3[2] && size < 4 && v[8*size-1]) v |= ~mask;
                rd_model = v;
            end
        end
    endtask

    initial begin
        bit [31:0] g_rd, g_addr, g_wd, r_addr, r_wd, r_rd;
        bit [3:0] g_be, e_be;
        bit g_we, r_r, r_w;
        bit [2:0] r_f3;
        int g_stall, g_req, g_mis, g_err, e_req, e_stall, e_mis, e_err, r_waits;
        bit [2:0] legal[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        add(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0,        2, 1, 0, 0);
        add(1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 32'hFFFFFF80, 4'h8, 32'h0,        2, 1, 0, 0);
        add(1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 2, 32'h00000080, 4'h8, 32'h0,        4, 3, 0, 0);
        add(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        3, 32'h00000080, 4'hC, 32'hABCDABCD, 5, 4, 0, 0);
        add(1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 32'h00000080, 4'h0, 32'h0,        1, 0, 1, 0);
        add(1, 0, 3'b001, 32'h102, 32'h0,        32'h80010000, 1, 32'hFFFF8001, 4'hC, 32'h0,        3, 2, 0, 0);
        add(1, 0, 3'b101, 32'h102, 32'h0,        32'h80010000, 0, 32'h00008001, 4'hC, 32'h0,        2, 1, 0, 0);
        add(1, 1, 3'b010, 32'h000, 32'h0,        32'h0,        0, 32'h00008001, 4'h0, 32'h0,        1, 0, 0, 1);
        add(1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        0, 32'h00008001, 4'h0, 32'h0,        1, 0, 0, 1);
        add(0, 1, 3'b100, 32'h000, 32'h0,        32'h0,        0, 32'h00008001, 4'h0, 32'h0,        1, 0, 0, 1);
        add(0, 1, 3'b000, 32'h001, 32'h0000005A, 32'h0,        0, 32'h00008001, 4'h2, 32'h5A5A5A5A, 2, 1, 0, 0);
        add(1, 0, 3'b001, 32'h003, 32'h0,        32'h0,        0, 32'h00008001, 4'h0, 32'h0,        1, 0, 1, 0);
        add(1, 0, 3'b000, 32'h002, 32'h0,        32'h007F0000, 0, 32'h0000007F, 4'h4, 32'h0,        2, 1, 0, 0);
        add(0, 1, 3'b010, 32'h0FC, 32'h12345678, 32'h0,        1, 32'h0000007F, 4'hF, 32'h12345678, 3, 2, 0, 0);

        #1;
        chk("reset readData", readData, 32'h0);
        chk("reset busReq", 32'(busReq), 32'h0);
        chk("reset busByteEn", 32'(busByteEn), 32'h0);
        chk("reset busAddr", busAddr, 32'h0);
        chk("reset stall", 32'(stall), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdata, tbl[i].waits,
                g_rd, g_addr, g_wd, g_be, g_we, g_stall, g_req, g_mis, g_err);
            chk($sformatf("v%0d readData", i), g_rd, tbl[i].e_rd);
            chk($sformatf("v%0d stall", i), g_stall, tbl[i].e_stall);
            chk($sformatf("v%0d busReq cycles", i), g_req, tbl[i].e_req);
            chk($sformatf("v%0d misaligned", i), g_mis, tbl[i].e_mis);
            chk($sformatf("v%0d busError", i), g_err, tbl[i].e_err);
            if (tbl[i].e_req > 0) begin
                chk($sformatf("v%0d busByteEn", i), 32'(g_be), 32'(tbl[i].e_be));
                chk($sformatf("v%0d busAddr", i), g_addr, tbl[i].addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d busWe", i), 32'(g_we), 32'(tbl[i].wr));
                if (tbl[i].wr) chk($sformatf("v%0d busWdata", i), g_wd, tbl[i].e_wd);
            end
        end

        // store that is never acked: the 4-cycle instance aborts, the no-timeout instance keeps waiting
        run(0, 1, 3'b010, 32'h200, 32'h12345678, 32'h0, 1000,
            g_rd, g_addr, g_wd, g_be, g_we, g_stall, g_req, g_mis, g_err);
        chk("timeout busReq cycles", g_req, 4);
        chk("timeout busError", g_err, 1);
        chk("timeout readData", g_rd, 32'h0);
        chk("timeout stall", g_stall, 5);
        repeat (20) @(negedge clk);
        #1;
        chk("no-timeout busReq", 32'(busReq_z), 32'h1);
        chk("no-timeout stall", 32'(stall_z), 32'h1);
        busAck = 1'b1;
        @(negedge clk);
        busAck = 1'b0;
        @(negedge clk);
        #1;
        chk("no-timeout released", 32'(busReq_z), 32'h0);

        // reset while a load waits on the bus
        run(1, 0, 3'b010, 32'h300, 32'h0, 32'h11223344, 0,
            g_rd, g_addr, g_wd, g_be, g_we, g_stall, g_req, g_mis, g_err);
        chk("pre-reset load", g_rd, 32'h11223344);
        memRead = 1'b1; funct3 = 3'b010; address = 32'h304; busAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("wait busReq", 32'(busReq), 32'h1);
        memRead = 1'b0;
        reset = 1'b1;
        #1;
        chk("async reset busReq", 32'(busReq), 32'h0);
        chk("async reset readData", readData, 32'h0);
        chk("async reset stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run(1, 0, 3'b010, 32'h308, 32'h0, 32'h55667788, 0,
            g_rd, g_addr, g_wd, g_be, g_we, g_stall, g_req, g_mis, g_err);
        chk("post-reset load", g_rd, 32'h55667788);
        chk("post-reset stall", g_stall, 2);
        rd_model = 32'h55667788;

        for (int n = 0; n < 150; n++) begin
            r_r = 1'($urandom_range(0, 1));
            r_w = ($urandom_range(0, 9) == 0) ? 1'b1 : ~r_r;
            r_f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
            r_addr = $urandom;
            r_wd = $urandom;
            r_rd = $urandom;
            r_waits = $urandom_range(0, 5);
            model(r_r, r_w, r_f3, r_addr, r_wd, r_rd, r_waits, e_req, e_stall, e_mis, e_err, e_be, g_wd);
            r_wd = r_wd;
            begin
                bit [31:0] e_wd;
                e_wd = g_wd;
                run(r_r, r_w, r_f3, r_addr, r_wd, r_rd, r_waits,
                    g_rd, g_addr, g_wd, g_be, g_we, g_stall, g_req, g_mis, g_err);
                chk($sformatf("r%0d readData", n), g_rd, rd_model);
                chk($sformatf("r%0d stall", n), g_stall, e_stall);
                chk($sformatf("r%0d busReq cycles", n), g_req, e_req);
                chk($sformatf("r%0d misaligned", n), g_mis, e_mis);
                chk($sformatf("r%0d busError", n), g_err, e_err);
                if (e_req > 0) begin
                    chk($sformatf("r%0d busByteEn", n), 32'(g_be), 32'(e_be));
                    chk($sformatf("r%0d busAddr", n), g_addr, r_addr & 32'hFFFF_FFFC);
                    if (r_w) chk($sformatf("r%0d busWdata", n), g_wd, e_wd);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Load/store stage directly downstream of the ALU in the single-cycle RISC-V datapath. It consumes the ALU result as the address, readData2 as store data, and control's memRead/memWrite/funct3. It runs a req/ack transaction on a variable-latency word-wide data bus, and stalls the datapath until that transaction completes. It returns sign- or zero-extended load data to the writeback mux.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles without busAck before aborting; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
memRead  input  1  load request from control
memWrite  input  1  store request from control
funct3  input  3  access size/sign (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu)
address  input  32  byte address (aluResult)
writeData  input  32  store data (readData2)
readData  output  32  formatted load result
stall  output  1  hold PC and register-file write while high
misaligned  output  1  one-cycle pulse on a misaligned access
busError  output  1  one-cycle pulse on illegal request or timeout
busReq  output  1  bus request, registered
busWe  output  1  1 = write, registered
busAddr  output  32  word address {address[31:2],2'b00}, registered
busWdata  output  32  lane-replicated store data, registered
busByteEn  output  4  byte lane enables, registered
busRdata  input  32  bus read data, valid when busAck=1
busAck  input  1  transaction complete, sampled only in WAIT

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; readData=0; busReq=0, busWe=0, busAddr=0, busWdata=0, busByteEn=0; misaligned=0; busError=0; timeout counter=0. A reset in mid-transaction drops busReq at once, and the bus must tolerate the abandoned access.
- FSM states: IDLE, WAIT, DONE.
- stall is combinational: 1 when (state==IDLE and (memRead or memWrite)), or when state==WAIT. Otherwise 0. It is 0 in DONE so the datapath advances on that edge.
- IDLE with no request: all outputs hold, no bus activity.
- IDLE with a request, checked in this order:
  (a) memRead and memWrite both high, a load funct3 in {011,110,111}, or a store funct3 other than 000/001/010 -> next state DONE, busError=1 in DONE, no bus access.
  (b) Misaligned access -> next state DONE, misaligned=1 in DONE, no bus access. Misaligned means halfword with address[0]=1, or word with address[1:0]!=0.
  (c) Otherwise register the bus fields, set busReq=1, clear the counter, next state WAIT.
- Byte enables: byte = 4'b0001<<address[1:0]; half = 4'b0011 when address[1]=0, else 4'b1100; word = 4'b1111. Loads drive the same enables.
- busWdata: byte store = writeData[7:0] replicated x4; half store = writeData[15:0] replicated x2; word store = writeData.
- WAIT: busReq/busWe/busAddr/busWdata/busByteEn held stable.
  - busAck=1 -> busReq=0 on the next edge, next state DONE. For a load, readData loads the formatted busRdata on the same edge.
  - busAck=0 -> counter increments. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ack -> busReq=0, next state DONE, busError=1 in DONE, readData=0.
- Load formatting: select lane address[1:0] (byte) or address[1] (half). lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- DONE: lasts exactly one cycle, then IDLE. misaligned and busError are 1 only here when flagged. Stores and error/misaligned cases leave readData unchanged, except a timeout, which clears it. readData holds until the next completed load.
- Latency with a zero-wait bus (ack in the first WAIT cycle): stall high for 2 cycles (IDLE, WAIT); readData valid in the DONE cycle, 3 cycles per access. Each extra wait cycle adds one cycle.
- A request present in IDLE immediately after DONE starts a new access (back-to-back loads/stores allowed).

Test Plan:
- lw address=0x100, bus returns 0xDEADBEEF with ack in the first WAIT cycle -> busAddr=0x100, busByteEn=1111, stall high 2 cycles, readData=0xDEADBEEF in DONE.
- lb address=0x103, busRdata=0x80FF_1234, then lbu to the same address -> busByteEn=1000; readData=0xFFFFFF80, then 0x00000080.
- sh address=0x102, writeData=0x0000ABCD, ack after 3 wait cycles -> busWe=1, busByteEn=1100, busWdata=0xABCDABCD, stall high 5 cycles, readData unchanged.
- lw address=0x101 -> no busReq, misaligned pulses for 1 cycle, stall high 1 cycle.
- TIMEOUT_CYCLES=4, sw with busAck never asserted -> busReq high for exactly 4 cycles, busError pulses, readData=0; with TIMEOUT_CYCLES=0 the request stays pending indefinitely.
- Assert reset in WAIT of a pending lw -> busReq=0 and readData=0 immediately (before the next clock edge); state is IDLE after release, and a later lw completes normally.
